// File: rtl/cpu_types_pkg.sv
// Geometry, address split, frame layout and FSM states for the 2-way data cache.
// The FCNT state only exists when DCACHE_HITCOUNT_EN is defined.
package cpu_types_pkg;
  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DSETS  = 8;
  localparam int DWAYS  = 2;
  localparam logic [31:0] HITCNT_ADDR = 32'h3100;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    logic [1:0][31:0]  data;
  } dcache_frame;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1,
`ifdef DCACHE_HITCOUNT_EN
    FCNT,
`endif
    DONE
  } dcache_state_t;
endpackage

// File: rtl/dcache_if.sv
// Datapath-side and memory-side signals of the data cache.
interface dcache_if;
  // dmemREN/dmemWEN are held with address/data until dhit; dREN/dWEN are held
  // with daddr/dstore until a cycle in which dwait is low completes the access.
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_way.sv
// Frame storage for one way of the data cache, with tag compare on the selected set.
module dcache_way
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DIDX_W-1:0] idx,
  input  logic [DTAG_W-1:0] tag,
  output logic              hit,
  output dcache_frame       frame,
  input  logic              wr_en,
  input  logic              wr_off,
  input  logic [31:0]       wr_data,
  input  logic              set_dirty,
  input  logic              clr_dirty,
  input  logic              fill
);
  dcache_frame frames [DSETS];

  assign frame = frames[idx];
  assign hit   = frame.valid && (frame.tag == tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DSETS; i++) frames[i] <= '0;
    end else begin
      if (wr_en)     frames[idx].data[wr_off] <= wr_data;
      if (set_dirty) frames[idx].dirty <= 1'b1;
      if (clr_dirty) frames[idx].dirty <= 1'b0;
      if (fill) begin
        frames[idx].valid <= 1'b1;
        frames[idx].dirty <= 1'b0;
        frames[idx].tag   <= tag;
      end
    end
  end
endmodule

// File: rtl/dcache.sv
// Write-back 2-way set-associative data cache with flush-on-halt.
// DCACHE_HITCOUNT_EN adds a hit-minus-miss counter written out at the end of the flush.
module dcache
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  dcache_if.slave       bus,
  output dcache_state_t state_dbg
);
  dcache_state_t     state, next;
  dcachef_t          req_a;
  logic [3:0]        fcnt;
  logic              fcnt_inc, lru_upd, hit_evt, miss_evt;
  logic [DSETS-1:0]  lru;
  logic [DIDX_W-1:0] idx;
  logic [DWAYS-1:0]  hit, wr_en, set_dirty, clr_dirty, fill;
  dcache_frame       frame [DWAYS];
  dcache_frame       vf;
  logic              wr_off, req, flushing, vway, hit_way;
  logic [31:0]       wr_data;
  logic              unused_bits;

`ifdef DCACHE_HITCOUNT_EN
  localparam dcache_state_t FLUSH_END = FCNT;
  logic signed [31:0] hitcnt;
`else
  localparam dcache_state_t FLUSH_END = DONE;
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

  assign req_a       = dcachef_t'(bus.dmemaddr);
  assign unused_bits = ^req_a.bytoff;
  assign req         = bus.dmemREN | bus.dmemWEN;
  assign flushing    = (state == FCHK) || (state == FWB0) || (state == FWB1);
  // The flush walks frames by counter; everything else addresses by the request.
  assign idx         = flushing ? fcnt[2:0] : req_a.idx;
  assign vway        = flushing ? fcnt[3] : lru[req_a.idx];
  assign vf          = frame[vway];
  assign hit_way     = hit[1];
  assign state_dbg   = state;

  for (genvar w = 0; w < DWAYS; w++) begin : g_way
    dcache_way u_way (
      .CLK(CLK), .nRST(nRST), .idx(idx), .tag(req_a.tag), .hit(hit[w]),
      .frame(frame[w]), .wr_en(wr_en[w]), .wr_off(wr_off), .wr_data(wr_data),
      .set_dirty(set_dirty[w]), .clr_dirty(clr_dirty[w]), .fill(fill[w])
    );
  end

  always_comb begin
    next         = state;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    wr_en        = '0;
    set_dirty    = '0;
    clr_dirty    = '0;
    fill         = '0;
    wr_off       = 1'b0;
    wr_data      = '0;
    lru_upd      = 1'b0;
    fcnt_inc     = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (req && (|hit)) begin
          bus.dhit     = 1'b1;
          bus.dmemload = frame[hit_way].data[req_a.blkoff];
          lru_upd      = 1'b1;
          hit_evt      = 1'b1;
          if (bus.dmemWEN) begin
            wr_en[hit_way]     = 1'b1;
            set_dirty[hit_way] = 1'b1;
            wr_off             = req_a.blkoff;
            wr_data            = bus.dmemstore;
          end
        end else if (req) begin
          miss_evt = 1'b1;
          next     = (vf.valid && vf.dirty) ? WB0 : LD0;
        end else if (bus.halt) begin
          next = FCHK;
        end
      end
      WB0, WB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {vf.tag, req_a.idx, state == WB1, 2'b00};
        bus.dstore = vf.data[state == WB1];
        if (!bus.dwait) next = (state == WB0) ? WB1 : LD0;
      end
      LD0, LD1: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_a.tag, req_a.idx, state == LD1, 2'b00};
        if (!bus.dwait) begin
          wr_en[vway] = 1'b1;
          wr_off      = (state == LD1);
          wr_data     = bus.dload;
          fill[vway]  = (state == LD1);
          next        = (state == LD0) ? LD1 : IDLE;
        end
      end
      FCHK: begin
        if (vf.valid && vf.dirty) next = FWB0;
        else if (fcnt == 4'hF)    next = FLUSH_END;
        else                      fcnt_inc = 1'b1;
      end
      FWB0, FWB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {vf.tag, fcnt[2:0], state == FWB1, 2'b00};
        bus.dstore = vf.data[state == FWB1];
        if (!bus.dwait) begin
          if (state == FWB0) begin
            next = FWB1;
          end else begin
            clr_dirty[vway] = 1'b1;
            if (fcnt == 4'hF) next = FLUSH_END;
            else begin
              fcnt_inc = 1'b1;
              next     = FCHK;
            end
          end
        end
      end
`ifdef DCACHE_HITCOUNT_EN
      FCNT: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = HITCNT_ADDR;
        bus.dstore = $unsigned(hitcnt);
        if (!bus.dwait) next = DONE;
      end
`endif
      DONE:    bus.flushed = 1'b1;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      fcnt  <= '0;
      lru   <= '0;
    end else begin
      state <= next;
      if (fcnt_inc) fcnt <= fcnt + 4'd1;
      if (lru_upd)  lru[req_a.idx] <= ~hit_way;
    end
  end

`ifdef DCACHE_HITCOUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         hitcnt <= '0;
    else if (hit_evt)  hitcnt <= hitcnt + 32'sd1;
    else if (miss_evt) hitcnt <= hitcnt - 32'sd1;
  end
`endif
endmodule
